// File: rtl/me_mb_scheduler.sv
// Raster-order macroblock scheduler for the ME core: one search per MB, address generation, result capture.
// Latency: frame_start -> LOAD next cycle, me_en one cycle later; me_data_valid -> res_valid next cycle.
// Backpressure: res_valid holds res_* stable until res_ready; the next search waits for that acceptance.
// Optional feature: define ME_SCHED_WATCHDOG_EN to abort a search after WDT_CYCLES RUN cycles (res_err=1).
module me_mb_scheduler #(
   parameter int MB_COLS    = 8,
   parameter int MB_ROWS    = 6,
   parameter int CUR_AW     = 16,
   parameter int REF_AW     = 18,
   parameter int CUR_WORDS  = 64,
   parameter int REF_WORDS  = 282,
   parameter int WDT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   output logic              busy,
   output logic              frame_done,
   output logic              me_en,
   input  logic              me_cur_read_en,
   input  logic              me_ref_read_en,
   input  logic              me_data_valid,
   input  logic [13:0]       me_msad,
   input  logic [4:0]        me_col,
   input  logic [4:0]        me_row,
   output logic [CUR_AW-1:0] cur_addr,
   output logic [REF_AW-1:0] ref_addr,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [13:0]       res_msad,
   output logic [4:0]        res_mv_x,
   output logic [4:0]        res_mv_y,
   output logic [7:0]        res_mb_x,
   output logic [7:0]        res_mb_y,
   output logic              res_err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

   state_t      state, state_nxt;
   logic [7:0]  mb_x, mb_y;
   logic [31:0] mb_index;
   logic        last_mb;
   logic        start_ok;
   logic        wdt_fire;

   assign mb_index = 32'(mb_y) * 32'(MB_COLS) + 32'(mb_x);
   assign last_mb  = (mb_x == 8'(MB_COLS - 1)) && (mb_y == 8'(MB_ROWS - 1));
   // A start landing on the frame_done cycle belongs to the old frame and is dropped.
   assign start_ok = frame_start && !frame_done;

`ifdef ME_SCHED_WATCHDOG_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);
   logic [WDT_W-1:0] wdt_cnt;

   assign wdt_fire = (state == RUN) && !me_data_valid && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

   // Watchdog counts RUN cycles of the current search, restarting with each LOAD.
   always_ff @(posedge clk) begin
      if (rst || state == LOAD)
         wdt_cnt <= '0;
      else if (state == RUN)
         wdt_cnt <= wdt_cnt + 1'b1;
   end
`else
   logic unused_wdt;

   assign wdt_fire   = 1'b0;
   assign res_err    = 1'b0;
   // Watchdog limit is meaningless without the abort feature.
   assign unused_wdt = ^WDT_CYCLES;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_ok) state_nxt = LOAD;
         LOAD: state_nxt = RUN;
         RUN:  if (me_data_valid || wdt_fire) state_nxt = HOLD;
         HOLD: if (res_ready) state_nxt = last_mb ? IDLE : LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs, raster position and address generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= 1'b0;
         frame_done <= 1'b0;
         me_en      <= 1'b0;
         cur_addr   <= '0;
         ref_addr   <= '0;
         res_valid  <= 1'b0;
         res_msad   <= '0;
         res_mv_x   <= '0;
         res_mv_y   <= '0;
         res_mb_x   <= '0;
         res_mb_y   <= '0;
         mb_x       <= '0;
         mb_y       <= '0;
`ifdef ME_SCHED_WATCHDOG_EN
         res_err    <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  mb_x <= '0;
                  mb_y <= '0;
                  busy <= 1'b1;
               end
            end
            LOAD: begin
               cur_addr <= CUR_AW'(mb_index * 32'(CUR_WORDS));
               ref_addr <= REF_AW'(mb_index * 32'(REF_WORDS));
               me_en    <= 1'b1;
            end
            RUN: begin
               if (me_cur_read_en) cur_addr <= cur_addr + 1'b1;
               if (me_ref_read_en) ref_addr <= ref_addr + 1'b1;
               if (me_data_valid) begin
                  res_msad  <= me_msad;
                  res_mv_x  <= me_col;
                  res_mv_y  <= me_row;
                  res_mb_x  <= mb_x;
                  res_mb_y  <= mb_y;
                  res_valid <= 1'b1;
                  me_en     <= 1'b0;
`ifdef ME_SCHED_WATCHDOG_EN
                  res_err   <= 1'b0;
`endif
               end else if (wdt_fire) begin
                  res_msad  <= 14'h3FFF;
                  res_mv_x  <= '0;
                  res_mv_y  <= '0;
                  res_mb_x  <= mb_x;
                  res_mb_y  <= mb_y;
                  res_valid <= 1'b1;
                  me_en     <= 1'b0;
`ifdef ME_SCHED_WATCHDOG_EN
                  res_err   <= 1'b1;
`endif
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (last_mb) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                  end else if (mb_x == 8'(MB_COLS - 1)) begin
                     mb_x <= '0;
                     mb_y <= mb_y + 8'd1;
                  end else begin
                     mb_x <= mb_x + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_me_mb_scheduler.sv
// Directed bench for me_mb_scheduler on a 2x2 macroblock frame.
// Latency: checks cycle-exact timing of busy, me_en, res_valid and frame_done.
// Backpressure: holds res_ready low across a result and checks nothing moves.
module tb_me_mb_scheduler;

   localparam int CW = 64;
   localparam int RW = 282;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic        busy, frame_done, me_en;
   logic        me_cur_read_en, me_ref_read_en, me_data_valid;
   logic [13:0] me_msad;
   logic [4:0]  me_col, me_row;
   logic [15:0] cur_addr;
   logic [17:0] ref_addr;
   logic        res_valid, res_ready;
   logic [13:0] res_msad;
   logic [4:0]  res_mv_x, res_mv_y;
   logic [7:0]  res_mb_x, res_mb_y;
   logic        res_err;

   int tests = 0;
   int fails = 0;

   me_mb_scheduler #(
      .MB_COLS(2), .MB_ROWS(2), .CUR_AW(16), .REF_AW(18),
      .CUR_WORDS(CW), .REF_WORDS(RW), .WDT_CYCLES(4096)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
      .me_en(me_en), .me_cur_read_en(me_cur_read_en), .me_ref_read_en(me_ref_read_en),
      .me_data_valid(me_data_valid), .me_msad(me_msad), .me_col(me_col), .me_row(me_row),
      .cur_addr(cur_addr), .ref_addr(ref_addr), .res_valid(res_valid), .res_ready(res_ready),
      .res_msad(res_msad), .res_mv_x(res_mv_x), .res_mv_y(res_mv_y),
      .res_mb_x(res_mb_x), .res_mb_y(res_mb_y), .res_err(res_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read strobes for lat cycles, starting on the first me_en cycle.
   task automatic strobes(input int ncur, input int nref, input int lat);
      for (int i = 0; i < lat; i++) begin
         me_cur_read_en = (i < ncur);
         me_ref_read_en = (i < nref);
         tick();
      end
      me_cur_read_en = 1'b0;
      me_ref_read_en = 1'b0;
   endtask

   task automatic deliver(input logic [13:0] msad, input logic [4:0] col, input logic [4:0] row);
      me_data_valid = 1'b1;
      me_msad       = msad;
      me_col        = col;
      me_row        = row;
      tick();
      me_data_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      frame_start = 1'b1;
      tick(); tick();
      frame_start = 1'b0;
      tick();
      tests++;
      if ({busy, frame_done, me_en, res_valid, res_err} !== 5'b0) begin
         fails++; $display("FAIL reset_flags got %b exp 00000", {busy, frame_done, me_en, res_valid, res_err});
      end
      tests++;
      if (cur_addr !== 16'd0 || ref_addr !== 18'd0) begin
         fails++; $display("FAIL reset_addr got cur=%0d ref=%0d exp 0 0", cur_addr, ref_addr);
      end
      tests++;
      if ({res_msad, res_mv_x, res_mv_y, res_mb_x, res_mb_y} !== 40'd0) begin
         fails++; $display("FAIL reset_res got %h exp 0", {res_msad, res_mv_x, res_mv_y, res_mb_x, res_mb_y});
      end
      rst = 1'b0;
      me_data_valid = 1'b1;
      me_cur_read_en = 1'b1;
      tick();
      me_data_valid = 1'b0;
      me_cur_read_en = 1'b0;
      tick();
      tests++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || cur_addr !== 16'd0) begin
         fails++; $display("FAIL idle_ignore got valid=%0b busy=%0b cur=%0d exp 0 0 0", res_valid, busy, cur_addr);
      end
   endtask

   task automatic test_frame();
      int x, y;
      res_ready = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tests++;
      if (busy !== 1'b1 || me_en !== 1'b0) begin
         fails++; $display("FAIL start_c1 got busy=%0b me_en=%0b exp 1 0", busy, me_en);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         x = k % 2;
         y = k / 2;
         tests++;
         if (me_en !== 1'b1 || cur_addr !== 16'(k * CW) || ref_addr !== 18'(k * RW)) begin
            fails++; $display("FAIL mb%0d_load got me_en=%0b cur=%0d ref=%0d exp 1 %0d %0d",
                              k, me_en, cur_addr, ref_addr, k * CW, k * RW);
         end
         if (k == 1) begin
            strobes(64, 10, 100);
            tests++;
            if (cur_addr !== 16'd128 || ref_addr !== 18'd292) begin
               fails++; $display("FAIL mb1_strobes got cur=%0d ref=%0d exp 128 292", cur_addr, ref_addr);
            end
         end else begin
            strobes(0, 0, 100);
         end
         deliver(14'(100 + k), 5'(k), 5'(k + 20));
         tests++;
         if (res_valid !== 1'b1 || me_en !== 1'b0 || busy !== 1'b1 || res_err !== 1'b0) begin
            fails++; $display("FAIL mb%0d_res_flags got valid=%0b me_en=%0b busy=%0b err=%0b exp 1 0 1 0",
                              k, res_valid, me_en, busy, res_err);
         end
         tests++;
         if (res_msad !== 14'(100 + k) || res_mv_x !== 5'(k) || res_mv_y !== 5'(k + 20) ||
             res_mb_x !== 8'(x) || res_mb_y !== 8'(y)) begin
            fails++; $display("FAIL mb%0d_res_data got msad=%0d mv=%0d,%0d mb=%0d,%0d exp %0d %0d,%0d %0d,%0d",
                              k, res_msad, res_mv_x, res_mv_y, res_mb_x, res_mb_y, 100 + k, k, k + 20, x, y);
         end
         tick();
         if (k < 3) begin
            tests++;
            if (res_valid !== 1'b0 || me_en !== 1'b0 || frame_done !== 1'b0) begin
               fails++; $display("FAIL mb%0d_accept got valid=%0b me_en=%0b done=%0b exp 0 0 0",
                                 k, res_valid, me_en, frame_done);
            end
            tick();
         end else begin
            tests++;
            if (frame_done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
               fails++; $display("FAIL frame_done got done=%0b busy=%0b valid=%0b exp 1 0 0",
                                 frame_done, busy, res_valid);
            end
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tests++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
               fails++; $display("FAIL done_pulse got done=%0b busy=%0b exp 0 0", frame_done, busy);
            end
            tick(); tick();
            tests++;
            if (busy !== 1'b0 || me_en !== 1'b0) begin
               fails++; $display("FAIL start_on_done got busy=%0b me_en=%0b exp 0 0", busy, me_en);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int bad;
      res_ready = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      strobes(5, 7, 20);
      deliver(14'h1234, 5'd3, 5'd30);
      tests++;
      if (res_valid !== 1'b1 || res_msad !== 14'h1234 || res_mb_x !== 8'd0 || res_mb_y !== 8'd0) begin
         fails++; $display("FAIL bp_first got valid=%0b msad=%h mb=%0d,%0d exp 1 1234 0,0",
                           res_valid, res_msad, res_mb_x, res_mb_y);
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         me_data_valid  = (i % 2 == 0);
         me_msad        = 14'h0AAA;
         me_col         = 5'd9;
         me_row         = 5'd9;
         frame_start    = (i == 10);
         me_cur_read_en = 1'b1;
         me_ref_read_en = 1'b1;
         tick();
         if (res_valid !== 1'b1 || res_msad !== 14'h1234 || res_mv_x !== 5'd3 || res_mv_y !== 5'd30 ||
             res_mb_x !== 8'd0 || res_mb_y !== 8'd0 || me_en !== 1'b0 || cur_addr !== 16'd5 ||
             ref_addr !== 18'd7 || busy !== 1'b1)
            bad++;
      end
      me_data_valid = 1'b0; frame_start = 1'b0; me_cur_read_en = 1'b0; me_ref_read_en = 1'b0;
      tests++;
      if (bad !== 0) begin
         fails++; $display("FAIL bp_hold_stable got %0d bad cycles exp 0", bad);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      tests++;
      if (res_valid !== 1'b0 || me_en !== 1'b0) begin
         fails++; $display("FAIL bp_release got valid=%0b me_en=%0b exp 0 0", res_valid, me_en);
      end
      tick();
      tests++;
      if (me_en !== 1'b1 || cur_addr !== 16'd64 || ref_addr !== 18'd282) begin
         fails++; $display("FAIL bp_next_load got me_en=%0b cur=%0d ref=%0d exp 1 64 282", me_en, cur_addr, ref_addr);
      end
      res_ready = 1'b1;
      strobes(0, 0, 30);
      deliver(14'h0055, 5'd1, 5'd2);
      tests++;
      if (res_mb_x !== 8'd1 || res_mb_y !== 8'd0 || res_msad !== 14'h0055) begin
         fails++; $display("FAIL bp_second got mb=%0d,%0d msad=%h exp 1,0 0055", res_mb_x, res_mb_y, res_msad);
      end
      tick(); tick();
      tests++;
      if (me_en !== 1'b1 || cur_addr !== 16'd128 || ref_addr !== 18'd564) begin
         fails++; $display("FAIL mb2_load got me_en=%0b cur=%0d ref=%0d exp 1 128 564", me_en, cur_addr, ref_addr);
      end
   endtask

   task automatic test_mid_reset();
      strobes(3, 3, 10);
      tests++;
      if (cur_addr !== 16'd131 || ref_addr !== 18'd567) begin
         fails++; $display("FAIL pre_rst got cur=%0d ref=%0d exp 131 567", cur_addr, ref_addr);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({busy, frame_done, me_en, res_valid, res_err} !== 5'b0 || cur_addr !== 16'd0 || ref_addr !== 18'd0 ||
          {res_msad, res_mv_x, res_mv_y, res_mb_x, res_mb_y} !== 40'd0) begin
         fails++; $display("FAIL mid_rst got flags=%b cur=%0d ref=%0d res=%h exp all 0",
                           {busy, frame_done, me_en, res_valid, res_err}, cur_addr, ref_addr,
                           {res_msad, res_mv_x, res_mv_y, res_mb_x, res_mb_y});
      end
      tick(); tick();
      tests++;
      if (busy !== 1'b0 || me_en !== 1'b0) begin
         fails++; $display("FAIL post_rst_idle got busy=%0b me_en=%0b exp 0 0", busy, me_en);
      end
      res_ready = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tests++;
      if (me_en !== 1'b1 || cur_addr !== 16'd0 || ref_addr !== 18'd0) begin
         fails++; $display("FAIL restart_load got me_en=%0b cur=%0d ref=%0d exp 1 0 0", me_en, cur_addr, ref_addr);
      end
      strobes(0, 0, 8);
      deliver(14'h0321, 5'd4, 5'd5);
      tests++;
      if (res_valid !== 1'b1 || res_mb_x !== 8'd0 || res_mb_y !== 8'd0 || res_msad !== 14'h0321) begin
         fails++; $display("FAIL restart_res got valid=%0b mb=%0d,%0d msad=%h exp 1 0,0 0321",
                           res_valid, res_mb_x, res_mb_y, res_msad);
      end
   endtask

   initial begin
      rst = 1'b1;
      frame_start = 1'b0;
      me_cur_read_en = 1'b0;
      me_ref_read_en = 1'b0;
      me_data_valid = 1'b0;
      me_msad = '0;
      me_col = '0;
      me_row = '0;
      res_ready = 1'b0;
      test_reset();
      test_frame();
      test_backpressure();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
